// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block width, GHASH reduction constant, controller state encoding.
package gcm_pkg;

    localparam int unsigned BLK_W = 128;

    typedef logic [0:BLK_W-1] blk_t;

    // Bit 0 is the GCM MSB, i.e. the x^0 coefficient.
    localparam blk_t GHASH_R = {8'b1110_0001, 120'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } ghash_st_t;

    // Pending multiply operand plus its end-of-message flag.
    typedef struct packed {
        blk_t data;
        logic last;
    } ghash_blk_t;

endpackage

// File: rtl/gfmul.sv
// Combinational GF(2^128) multiply in GCM bit order (shift-and-add with reduction by GHASH_R).
module gfmul
    import gcm_pkg::*;
(
    input  logic [0:BLK_W-1] iCtext,
    input  logic [0:BLK_W-1] iHashkey,
    output logic [0:BLK_W-1] oResult
);

    blk_t z;
    blk_t v;

    always_comb begin
        z = '0;
        v = iHashkey;
        for (int i = 0; i < int'(BLK_W); i++) begin
            if (iCtext[i]) begin
                z = z ^ v;
            end
            if (v[BLK_W-1]) begin
                v = {1'b0, v[0:BLK_W-2]} ^ GHASH_R;
            end else begin
                v = {1'b0, v[0:BLK_W-2]};
            end
        end
        oResult = z;
    end

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: Y <= (Y ^ X) * H per accepted block.
// Define GHASH_PIPE_EN to register Y^X ahead of the multiplier (one block per two cycles).
module ghash_ctrl
    import gcm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iStart,
    input  logic [0:BLK_W-1] iHashkey,
    input  logic             iValid,
    input  logic [0:BLK_W-1] iBlock,
    input  logic             iLast,
    output logic             oReady,
    output logic             oDone,
    output logic [0:BLK_W-1] oGhash,
    output logic [CNT_W-1:0] oBlkCnt
);

    ghash_st_t         state_q, state_d;
    blk_t              h_q, h_d;
    blk_t              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    blk_t              mul_in;
    blk_t              mul_out;
    logic              accept;

`ifdef GHASH_PIPE_EN
    ghash_blk_t        p_q, p_d;

    assign mul_in = p_q.data;
`else
    assign mul_in = y_q ^ iBlock;
`endif

    gfmul u_gfmul (
        .iCtext   (mul_in),
        .iHashkey (h_q),
        .oResult  (mul_out)
    );

    // A start request always wins, so no block is taken in the same cycle.
    assign oReady = (state_q == ACC) && !iStart;
    assign accept = iValid && oReady;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
`ifdef GHASH_PIPE_EN
        p_d     = p_q;
`endif
        if (iStart) begin
            h_d     = iHashkey;
            y_d     = '0;
            cnt_d   = '0;
            state_d = ACC;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef GHASH_PIPE_EN
                        p_d     = '{data: y_q ^ iBlock, last: iLast};
                        state_d = MUL;
`else
                        y_d     = mul_out;
                        state_d = iLast ? DONE : ACC;
`endif
                    end
                end
                MUL: begin
`ifdef GHASH_PIPE_EN
                    y_d     = mul_out;
                    state_d = p_q.last ? DONE : ACC;
`else
                    state_d = IDLE;
`endif
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            h_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef GHASH_PIPE_EN
            p_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef GHASH_PIPE_EN
            p_q     <= p_d;
`endif
        end
    end

    assign oDone   = done_q;
    assign oGhash  = y_q;
    assign oBlkCnt = cnt_q;

endmodule
